// File: rtl/vga_timing_if.sv
// Raster timing bundle produced by vga_timing: pixel coordinates, blanking,
// sync and frame strobes. The timing generator drives it; draw stages observe it.
interface vga_timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [15:0] frame_cnt;

    // Free-running stream with no valid/ready: every cycle carries one pixel.
    modport master (
        output hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start, frame_cnt
    );
    modport slave (
        input  hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing.sv
// 1024x768@60 raster timing generator with registered, skew-free outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
    parameter int H_TOTAL      = 1344,
    parameter int H_ACTIVE     = 1024,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_END   = 1184,
    parameter int V_TOTAL      = 806,
    parameter int V_ACTIVE     = 768,
    parameter int V_SYNC_START = 771,
    parameter int V_SYNC_END   = 777
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master o_vga
);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
    localparam logic [10:0] H_SE   = 11'(H_SYNC_END);
    localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
    localparam logic [10:0] V_SE   = 11'(V_SYNC_END);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;

    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_wrap;

    // Flags are derived from the next-state counters so they land in the
    // same register stage as the coordinates they describe.
    always_comb begin
        w_h_last     = (r_hcount == H_LAST);
        w_v_last     = (r_vcount == V_LAST);
        w_frame_wrap = w_h_last && w_v_last;
        w_hcount_nxt = r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_hcount_nxt = 11'd0;
            w_vcount_nxt = w_v_last ? 11'd0 : r_vcount + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblnk       <= (w_hcount_nxt >= H_ACT);
            r_vblnk       <= (w_vcount_nxt >= V_ACT);
            r_hsync       <= (w_hcount_nxt >= H_SS) && (w_hcount_nxt < H_SE);
            r_vsync       <= (w_vcount_nxt >= V_SS) && (w_vcount_nxt < V_SE);
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'h0000;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
        end
    end

    assign o_vga.frame_cnt = r_frame_cnt;
`else
    assign o_vga.frame_cnt = 16'h0000;
`endif

    assign o_vga.hcount      = r_hcount;
    assign o_vga.vcount      = r_vcount;
    assign o_vga.hblnk       = r_hblnk;
    assign o_vga.vblnk       = r_vblnk;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.frame_start = r_frame_start;
endmodule
